// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined Hack-style ALU.
//
// Every one of the 64 control codes (zx,nx,zy,ny,f,no) is decoded, so
// undocumented codes still give a well-defined result. A sideband tag
// travels with each operation and comes out with its result.
//
// Optional feature: define ALU_PIPE_CARRY_OV_EN to add the out_cy / out_ov
// ports. They carry the carry-out and signed overflow of the xb+yb adder.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation offered
//   in_ready   operation accepted when in_valid && in_ready
//   in_x/in_y  operands (WIDTH)
//   in_c       control word, bit5..0 = zx,nx,zy,ny,f,no
//   in_tag     sideband tag (TAG_W)
//   out_valid  result present
//   out_ready  consumer accepts when out_valid && out_ready
//   out_data   result (WIDTH)
//   out_zr     result == 0
//   out_ng     result MSB
//   out_tag    tag of the result
//   out_cy     carry out of xb+yb (ALU_PIPE_CARRY_OV_EN only)
//   out_ov     signed overflow of xb+yb (ALU_PIPE_CARRY_OV_EN only)

module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [5:0]       in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zr,
  output logic             out_ng,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_PIPE_CARRY_OV_EN
  ,
  output logic             out_cy,
  output logic             out_ov
`endif
);

  logic             v1;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic [5:0]       c1;
  logic [TAG_W-1:0] t1;

  logic             en1;
  logic             en2;

  logic [WIDTH-1:0] xa, xb, ya, yb, r, f_res;
`ifdef ALU_PIPE_CARRY_OV_EN
  logic [WIDTH:0]   sum_ext;
  logic             cy_nxt;
  logic             ov_nxt;
`else
  logic [WIDTH-1:0] sum;
`endif

  // Stage 2 frees up when empty or draining; stage 1 frees up when empty or
  // when stage 2 will take its contents this cycle.
  assign en2      = !out_valid || out_ready;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  always_comb begin
    xa = c1[5] ? '0 : x1;
    xb = c1[4] ? ~xa : xa;
    ya = c1[3] ? '0 : y1;
    yb = c1[2] ? ~ya : ya;
`ifdef ALU_PIPE_CARRY_OV_EN
    sum_ext = {1'b0, xb} + {1'b0, yb};
    r       = c1[1] ? sum_ext[WIDTH-1:0] : (xb & yb);
    // Flags describe the adder itself, before the optional output inversion.
    cy_nxt  = c1[1] & sum_ext[WIDTH];
    ov_nxt  = c1[1] & (xb[WIDTH-1] == yb[WIDTH-1]) &
              (sum_ext[WIDTH-1] != xb[WIDTH-1]);
`else
    sum     = xb + yb;
    r       = c1[1] ? sum : (xb & yb);
`endif
    f_res = c1[0] ? ~r : r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      x1        <= '0;
      y1        <= '0;
      c1        <= '0;
      t1        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zr    <= 1'b1;
      out_ng    <= 1'b0;
      out_tag   <= '0;
`ifdef ALU_PIPE_CARRY_OV_EN
      out_cy    <= 1'b0;
      out_ov    <= 1'b0;
`endif
    end else begin
      if (en1) begin
        v1 <= in_valid;
        if (in_valid) begin
          x1 <= in_x;
          y1 <= in_y;
          c1 <= in_c;
          t1 <= in_tag;
        end
      end
      if (en2) begin
        out_valid <= v1;
        // Bubbles leave the last result in place rather than clearing it.
        if (v1) begin
          out_data <= f_res;
          out_zr   <= (f_res == '0);
          out_ng   <= f_res[WIDTH-1];
          out_tag  <= t1;
`ifdef ALU_PIPE_CARRY_OV_EN
          out_cy   <= cy_nxt;
          out_ov   <= ov_nxt;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_x, in_y, out_data;
  logic [5:0]  in_c;
  logic [3:0]  in_tag, out_tag;
  logic        out_zr, out_ng;

  logic        in_valid8, in_ready8, out_valid8;
  logic [7:0]  in_x8, in_y8, out_data8;
  logic [5:0]  in_c8;
  logic [3:0]  in_tag8, out_tag8;
  logic        out_zr8, out_ng8;
`ifdef ALU_PIPE_CARRY_OV_EN
  logic        out_cy, out_ov, out_cy8, out_ov8;
`endif

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_c(in_c), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zr(out_zr), .out_ng(out_ng), .out_tag(out_tag)
`ifdef ALU_PIPE_CARRY_OV_EN
    , .out_cy(out_cy), .out_ov(out_ov)
`endif
  );

  alu_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_x(in_x8), .in_y(in_y8), .in_c(in_c8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(1'b1),
    .out_data(out_data8), .out_zr(out_zr8), .out_ng(out_ng8), .out_tag(out_tag8)
`ifdef ALU_PIPE_CARRY_OV_EN
    , .out_cy(out_cy8), .out_ov(out_ov8)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        zr, ng;
    logic [3:0]  tag;
    logic        cy, ov;
  } exp_t;

  // Reference ALU on plain integers, straight from the zx/nx/zy/ny/f/no rules.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic [5:0] c, input logic [3:0] tag);
    exp_t e;
    int unsigned xv, yv, r, s;
    int sx, sy;
    xv = c[5] ? 0 : 32'(x);
    if (c[4]) xv = 65535 - xv;
    yv = c[3] ? 0 : 32'(y);
    if (c[2]) yv = 65535 - yv;
    s  = xv + yv;
    r  = c[1] ? (s % 65536) : (xv & yv);
    if (c[0]) r = 65535 - r;
    e.d   = r[15:0];
    e.zr  = (r == 0);
    e.ng  = (r >= 32768);
    e.tag = tag;
    sx = (xv >= 32768) ? int'(xv) - 65536 : int'(xv);
    sy = (yv >= 32768) ? int'(yv) - 65536 : int'(yv);
    e.cy = c[1] && (s > 65535);
    e.ov = c[1] && ((sx + sy) > 32767 || (sx + sy) < -32768);
    return e;
  endfunction

  exp_t        q[$];
  int          acc_cnt = 0;
  int          out_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] sv_data;
  logic [3:0]  sv_tag;
  logic        sv_zr, sv_ng;

  // One clock: observe handshakes at the negedge, then return #1 after the
  // next rising edge so the caller can drive the following cycle's inputs.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (stall_prev) begin
      chk("stall_data", 32'(out_data), 32'(sv_data));
      chk("stall_tag", 32'(out_tag), 32'(sv_tag));
      chk("stall_flags", {30'd0, out_zr, out_ng}, {30'd0, sv_zr, sv_ng});
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    stall_prev = out_valid && !out_ready;
    sv_data = out_data; sv_tag = out_tag; sv_zr = out_zr; sv_ng = out_ng;
    if (out_valid && out_ready) begin
      out_cnt++;
      if (q.size() == 0) begin
        chk("spurious_output", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("data", 32'(out_data), 32'(e.d));
        chk("flags_zr_ng", {30'd0, out_zr, out_ng}, {30'd0, e.zr, e.ng});
        chk("tag", 32'(out_tag), 32'(e.tag));
`ifdef ALU_PIPE_CARRY_OV_EN
        chk("cy_ov", {30'd0, out_cy, out_ov}, {30'd0, e.cy, e.ov});
`endif
      end
    end
    if (in_valid && in_ready) begin
      acc_cnt++;
      q.push_back(model(in_x, in_y, in_c, in_tag));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] x, y;
    logic [5:0]  c;
    logic [3:0]  tag;
    logic [15:0] d;
    logic        zr, ng;
  } vec_t;

  typedef struct {
    logic [15:0] x, y;
    logic [5:0]  c;
    logic [15:0] d;
    logic        cy, ov;
  } cvec_t;

  initial begin
    vec_t  tbl[10];
    cvec_t ctbl[4];
    logic [7:0] e8[3];
    logic [5:0] c8[3];
    int n, start_out;

    tbl[0] = '{16'd5,      16'd3,      6'b000010, 4'd7, 16'h0008, 1'b0, 1'b0};
    tbl[1] = '{16'd3,      16'd5,      6'b010011, 4'd1, 16'hFFFE, 1'b0, 1'b1};
    tbl[2] = '{16'd3,      16'd5,      6'b101010, 4'd2, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{16'd3,      16'd5,      6'b111111, 4'd3, 16'h0001, 1'b0, 1'b0};
    tbl[4] = '{16'h1234,   16'h9999,   6'b111010, 4'd4, 16'hFFFF, 1'b0, 1'b1};
    tbl[5] = '{16'h1234,   16'h9999,   6'b001100, 4'd5, 16'h1234, 1'b0, 1'b0};
    tbl[6] = '{16'h1234,   16'hABCD,   6'b110000, 4'd6, 16'hABCD, 1'b0, 1'b1};
    tbl[7] = '{16'd3,      16'd5,      6'b000111, 4'd8, 16'h0002, 1'b0, 1'b0};
    tbl[8] = '{16'hF0F0,   16'hFF00,   6'b000000, 4'd9, 16'hF000, 1'b0, 1'b1};
    tbl[9] = '{16'hF0F0,   16'h0F00,   6'b010101, 4'hF, 16'hFFF0, 1'b0, 1'b1};

    ctbl[0] = '{16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1};
    ctbl[1] = '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0};
    ctbl[2] = '{16'hFFFF, 16'hFFFF, 6'b000000, 16'hFFFF, 1'b0, 1'b0};
    ctbl[3] = '{16'd3,    16'd5,    6'b010011, 16'hFFFE, 1'b1, 1'b0};

    c8[0] = 6'b000000; e8[0] = 8'h05;
    c8[1] = 6'b010101; e8[1] = 8'hAF;
    c8[2] = 6'b001101; e8[2] = 8'h5A;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0; in_c = '0; in_tag = '0;
    in_valid8 = 1'b0; in_x8 = '0; in_y8 = '0; in_c8 = '0; in_tag8 = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", {30'd0, out_zr, out_ng}, 32'b10);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table: one operation at a time, latency checked exactly.
    foreach (tbl[i]) begin
      in_x = tbl[i].x; in_y = tbl[i].y; in_c = tbl[i].c; in_tag = tbl[i].tag;
      in_valid = 1'b1;
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("tbl_lat1_valid", 32'(out_valid), 32'd0);
      step();
      chk("tbl_lat2_valid", 32'(out_valid), 32'd1);
      chk("tbl_data", 32'(out_data), 32'(tbl[i].d));
      chk("tbl_flags", {30'd0, out_zr, out_ng}, {30'd0, tbl[i].zr, tbl[i].ng});
      chk("tbl_tag", 32'(out_tag), 32'(tbl[i].tag));
      step();
      chk("tbl_drained", 32'(out_valid), 32'd0);
    end

`ifdef ALU_PIPE_CARRY_OV_EN
    foreach (ctbl[i]) begin
      in_x = ctbl[i].x; in_y = ctbl[i].y; in_c = ctbl[i].c; in_tag = 4'd0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("cy_data", 32'(out_data), 32'(ctbl[i].d));
      chk("cy_ov_flags", {30'd0, out_cy, out_ov}, {30'd0, ctbl[i].cy, ctbl[i].ov});
      chk("cy_zr_ng", {30'd0, out_zr, out_ng},
          {30'd0, (ctbl[i].d == 16'd0), ctbl[i].d[15]});
      step();
    end
`endif

    // 8-bit instance: logic ops on narrow width.
    foreach (c8[i]) begin
      in_x8 = 8'hA5; in_y8 = 8'h0F; in_c8 = c8[i]; in_tag8 = 4'(i);
      in_valid8 = 1'b1;
      step();
      in_valid8 = 1'b0;
      step();
      chk("w8_valid", 32'(out_valid8), 32'd1);
      chk("w8_data", 32'(out_data8), 32'(e8[i]));
      chk("w8_ng", 32'(out_ng8), 32'(e8[i][7]));
      step();
    end

    // Backpressure: four ops with out_ready low, then release.
    stall_prev = 1'b0;
    acc_cnt = 0; out_cnt = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (acc_cnt < 4);
      in_x = 16'(acc_cnt * 100); in_y = 16'd7; in_c = 6'b000010; in_tag = 4'(acc_cnt);
      cycle();
    end
    chk("bp_accepts", 32'(acc_cnt), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_tag_held", 32'(out_tag), 32'd0);
    out_ready = 1'b1;
    n = 0;
    while ((acc_cnt < 4 || q.size() > 0) && n < 20) begin
      in_valid = (acc_cnt < 4);
      in_x = 16'(acc_cnt * 100); in_y = 16'd7; in_c = 6'b000010; in_tag = 4'(acc_cnt);
      cycle();
      n++;
    end
    in_valid = 1'b0;
    chk("bp_drain_cycles", 32'(n), 32'd4);
    chk("bp_out_count", 32'(out_cnt), 32'd4);

    // Reset with the pipe full discards both in-flight ops.
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 16'd1; in_y = 16'd2; in_c = 6'b000010; in_tag = 4'd3;
    cycle(); cycle();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    q.delete(); stall_prev = 1'b0;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data", 32'(out_data), 32'd0);
    chk("mrst_zr", 32'(out_zr), 32'd1);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    out_cnt = 0;
    in_valid = 1'b1; in_x = 16'd1; in_y = 16'd1; in_c = 6'b000010; in_tag = 4'd9;
    cycle();
    in_valid = 1'b0;
    n = 0;
    while (out_cnt == 0 && n < 5) begin
      cycle();
      n++;
    end
    chk("mrst_first_result_seen", 32'(out_cnt), 32'd1);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_x   = 16'($urandom);
      in_y   = 16'($urandom);
      in_c   = 6'($urandom);
      in_tag = 4'($urandom);
      if ($urandom_range(7) == 0) in_x = 16'hFFFF;
      if ($urandom_range(7) == 0) in_y = 16'h8000;
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 10) begin
      cycle();
      n++;
    end
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    start_out = out_cnt;
    cycle(); cycle();
    chk("no_extra_outputs", 32'(out_cnt), 32'(start_out));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
